// File: rtl/lock_dialer_if.sv
// lock_dialer_if -- signal bundle between the auto-dialer and its surroundings.
//   master : the dialer (drives the lock's SW bus/enter and the status outputs)
//   slave  : host + lock side (drives start/code_in and the decoded lock status)
// Signals:
//   start, code_in          host request (packed BCD, digit 0 in [3:0])
//   lock_open, lock_closed  decoded lock status
//   digit_out, enter        lock SW bus value and digit-capture strobe
//   busy, done              sequence in progress / one-cycle completion pulse
//   result_open, err        verdict of the last sequence, held until next start
interface lock_dialer_if #(
  parameter int DIGITS = 6
);
  logic                  start;
  logic [4*DIGITS-1:0]   code_in;
  logic                  lock_open;
  logic                  lock_closed;
  logic [9:0]            digit_out;
  logic                  enter;
  logic                  busy;
  logic                  done;
  logic                  result_open;
  logic                  err;

  modport master (
    input  start, code_in, lock_open, lock_closed,
    output digit_out, enter, busy, done, result_open, err
  );

  modport slave (
    output start, code_in, lock_open, lock_closed,
    input  digit_out, enter, busy, done, result_open, err
  );
endinterface

// File: rtl/lock_dialer.sv
// lock_dialer -- drives a combination lock's digit-entry interface from a
// packed BCD passcode: each digit is held on the SW bus for GAP settle cycles,
// then captured with a one-cycle enter strobe. After the last digit the lock's
// decoded open/closed status is sampled (bounded by RESP_WAIT cycles) and the
// verdict is reported with a one-cycle done pulse.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   dif    lock_dialer_if.master (start/code_in in, SW bus + status out)
// All outputs are registered.

// Per-digit BCD range check; one instance per passcode digit.
module lock_dialer_digit_chk (
  input  logic [3:0] digit,
  output logic       bad
);
  assign bad = (digit > 4'd9);
endmodule

module lock_dialer #(
  parameter int DIGITS    = 6,
  parameter int GAP       = 2,
  parameter int RESP_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  lock_dialer_if.master dif
);
  localparam int IW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;
  localparam int GW = (GAP       > 1) ? $clog2(GAP)       : 1;
  localparam int TW = (RESP_WAIT > 1) ? $clog2(RESP_WAIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT_RESULT,
    DONE
  } state_t;

  state_t                 state;
  logic [DIGITS-1:0][3:0] code_q;
  logic [IW-1:0]          idx;
  logic [GW-1:0]          gap_cnt;
  logic [TW-1:0]          wait_cnt;
  logic [9:0]             digit_q;
  logic                   enter_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   ro_q;
  logic                   err_q;
  logic [DIGITS-1:0]      digit_bad;

  // Checked on the raw input: the accept decision is made on the same edge
  // that latches code_in, so the latched copy is not yet available.
  for (genvar i = 0; i < DIGITS; i++) begin : g_chk
    lock_dialer_digit_chk u_chk (
      .digit (dif.code_in[4*i +: 4]),
      .bad   (digit_bad[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      code_q   <= '0;
      idx      <= '0;
      gap_cnt  <= '0;
      wait_cnt <= '0;
      digit_q  <= '0;
      enter_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ro_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // enter and done are single-cycle pulses
      enter_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dif.start) begin
            code_q   <= dif.code_in;
            ro_q     <= 1'b0;
            err_q    <= 1'b0;
            idx      <= '0;
            gap_cnt  <= '0;
            wait_cnt <= '0;
            if (|digit_bad) begin
              // reject without touching the lock: no busy, no strobes
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              busy_q  <= 1'b1;
              digit_q <= {6'd0, dif.code_in[3:0]};
              state   <= SETUP;
            end
          end
        end

        SETUP: begin
          // digit_q already valid; count GAP settle cycles before the strobe
          if (gap_cnt == GW'(GAP - 1)) begin
            gap_cnt <= '0;
            enter_q <= 1'b1;
            state   <= STROBE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        STROBE: begin
          if (idx == IW'(DIGITS - 1)) begin
            // last digit stays on the bus while the verdict is awaited
            wait_cnt <= '0;
            state    <= WAIT_RESULT;
          end else begin
            idx     <= idx + IW'(1);
            digit_q <= {6'd0, code_q[idx + IW'(1)]};
            state   <= SETUP;
          end
        end

        WAIT_RESULT: begin
          // a verdict seen in the final wait cycle still wins over timeout
          if (dif.lock_open ^ dif.lock_closed) begin
            ro_q    <= dif.lock_open;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            digit_q <= '0;
            state   <= DONE;
          end else if (dif.lock_open & dif.lock_closed) begin
            ro_q    <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            digit_q <= '0;
            state   <= DONE;
          end else if (wait_cnt == TW'(RESP_WAIT - 1)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            digit_q <= '0;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end

        DONE: begin
          // start is ignored here; the next request is taken in IDLE
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign dif.digit_out   = digit_q;
  assign dif.enter       = enter_q;
  assign dif.busy        = busy_q;
  assign dif.done        = done_q;
  assign dif.result_open = ro_q;
  assign dif.err         = err_q;
endmodule

// File: doc/lock_dialer.md
# lock_dialer

Synthesizable auto-dialer that drives the combination lock's digit-entry interface from the other side: it takes a packed BCD passcode and presents it one digit at a time on the lock's switch bus with an enter strobe in place of the key press. It then samples the lock's decoded open/closed status and reports the verdict. It sits beside the lock in the lab top level for self-test and demo, and replaces a human operator working the switches and entry key.

## Interface
- DIGITS, 6: passcode length in digits.
- GAP, 2: settle cycles that digit_out is held before each enter strobe (≥1).
- RESP_WAIT, 4: maximum cycles to wait for a lock verdict after the last strobe (≥1).

- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a dial sequence; sampled only in IDLE.
- code_in  in  4*DIGITS  packed BCD passcode; digit 0 in [3:0] is entered first.
- lock_open  in  1  lock reports open (decoded "OPEN" status).
- lock_closed  in  1  lock reports closed (decoded "CLOSED" status).
- digit_out  out  10  value driven onto the lock's SW bus, zero-extended digit.
- enter  out  1  one-cycle digit-capture strobe to the lock.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- result_open  out  1  last verdict was open; held until next accepted start.
- err  out  1  last sequence failed (bad digit, timeout, conflicting status); held until next accepted start.

## Operation
- States: IDLE, SETUP, STROBE, WAIT_RESULT, DONE.
- Reset (any time, including mid-sequence) forces IDLE. All outputs 0, digit index 0, counters 0. No enter strobe is produced until a new start.
- IDLE + start=1:
  - code_in is latched, and result_open/err are cleared.
  - If any latched digit is >9: err=1, go to DONE, no strobes issued.
  - Otherwise: index=0, go to SETUP.
- IDLE + start=0: stay.
- SETUP: digit_out = latched digit[index]; busy=1. Hold for GAP cycles, then go to STROBE.
- STROBE: enter=1 for exactly one cycle; digit_out unchanged.
  - If index = DIGITS-1: go to WAIT_RESULT.
  - Otherwise: index+1, go to SETUP.
- WAIT_RESULT: digit_out holds the last digit; timeout counter runs.
  - Exactly one of lock_open/lock_closed high: result_open=lock_open, go to DONE.
  - Both high: err=1, result_open=0, go to DONE.
  - Neither high after RESP_WAIT cycles: err=1, go to DONE.
- DONE: done=1 for one cycle; busy=0; digit_out=0; then go to IDLE.
- start while busy or in DONE is ignored. code_in changes after acceptance have no effect.
- Index and counters never wrap: index is bounded by DIGITS-1, and the timeout counter saturates at RESP_WAIT.

## Timing
- start sampled high at edge k: from k+1 busy=1, digit_out=digit 0.
- Digit i: enter high during cycle k+1+i*(GAP+1)+GAP; per-digit period is GAP+1 cycles.
- Lock samples digit_out on the enter cycle; digit_out is stable GAP cycles before and during the strobe.
- Verdict sampled from the cycle after the last strobe. A verdict visible w cycles later (w<RESP_WAIT) gives done at the following cycle.
- Defaults, immediate verdict: last enter at k+18, done at k+20, earliest next start accepted at k+21.
- Invalid digit: done at k+1, busy never asserted, enter never asserted.
- result_open/err update on the same edge done rises and remain stable through IDLE.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Correct code 6,3,2,9,1,4 into a behavioural lock that opens on a match: six enter pulses carrying 6,3,2,9,1,4 at the computed cycles. Then done=1, result_open=1, err=0.
- Each position in turn replaced by 8, lock reports closed: still six strobes, digit 8 at the failing slot; done=1, result_open=0, err=0.
- code_in digit 2 = 12 (others valid): done one cycle after start, err=1, zero enter pulses, busy never high.
- Lock never answers: done RESP_WAIT+1 cycles after the last strobe, err=1. Lock answers with both flags: err=1, result_open=0.
- rst_n pulsed low between the 3rd and 4th strobe: all outputs 0 immediately (asynchronously), no further strobes. A fresh start redials from digit 0.
- start held high for the whole sequence and pulsed again mid-dial: exactly one sequence runs. The next sequence is accepted only once back in IDLE.
